// File: rtl/sdram_layer_pkg.sv
// ---------------------------------------------------------------------------
// sdram_layer_pkg
// Shared definitions for the SDRAM fully-connected layer engine:
//   - state_t        : layer-pass FSM states
//   - BE_ALL_ONES    : byteenable source constant (slice to DATA_W/8 bits)
//   - sat_to_data_w  : clamps a sign-extended accumulator to a signed
//                      data_w-bit range (result still 64 bits wide)
// ---------------------------------------------------------------------------
package sdram_layer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_IN = 3'd1,
      ST_FETCH_W = 3'd2,
      ST_WRITE   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [63:0] BE_ALL_ONES = {64{1'b1}};

   function automatic logic signed [63:0] sat_to_data_w(
      input logic signed [63:0] i_acc,
      input int unsigned        i_data_w
   );
      logic signed [63:0] w_hi;
      logic signed [63:0] w_lo;
      w_hi = (64'sd1 <<< (i_data_w - 32'd1)) - 64'sd1;
      w_lo = -w_hi - 64'sd1;
      if (i_acc > w_hi) begin
         return w_hi;
      end else if (i_acc < w_lo) begin
         return w_lo;
      end else begin
         return i_acc;
      end
   endfunction

endpackage

// File: rtl/sdram_rd_tracker.sv
// ---------------------------------------------------------------------------
// sdram_rd_tracker
// Bookkeeping for in-order Avalon reads.
//   clk, reset    : clock, synchronous active-high reset
//   i_clr         : synchronous clear (held while the engine is idle)
//   i_rd_acc      : a read was accepted this cycle
//   i_rdv         : a relevant readdatavalid arrived this cycle
//   o_pend        : reads accepted but not yet returned
//   o_issue_ok    : next cycle may present a new read (pend after this
//                   cycle's accept/return is below MAX_PEND)
//   o_ret_idx     : word index (0..N_IN-1) of the current return
//   o_ret_last    : current return is word N_IN-1 of its row/vector
// ---------------------------------------------------------------------------
module sdram_rd_tracker
   import sdram_layer_pkg::*;
#(
   parameter int N_IN     = 784,
   parameter int MAX_PEND = 8,
   parameter int PEND_W   = $clog2(MAX_PEND + 1),
   parameter int IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_rd_acc,
   input  logic              i_rdv,
   output logic [PEND_W-1:0] o_pend,
   output logic              o_issue_ok,
   output logic [IDX_W-1:0]  o_ret_idx,
   output logic              o_ret_last
);

   logic [PEND_W-1:0] r_pend;
   logic [PEND_W-1:0] w_pend_next;
   logic [IDX_W-1:0]  r_ret_idx;

   // Next outstanding count: accept and return in one cycle cancel out.
   always_comb begin
      w_pend_next = r_pend;
      if (i_rd_acc && !i_rdv) begin
         w_pend_next = r_pend + PEND_W'(1);
      end else if (!i_rd_acc && i_rdv && (r_pend != '0)) begin
         w_pend_next = r_pend - PEND_W'(1);
      end else begin
         w_pend_next = r_pend;
      end
   end

   // Outstanding counter and wrapping return index.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_pend    <= '0;
         r_ret_idx <= '0;
      end else begin
         r_pend <= w_pend_next;
         if (i_rdv) begin
            r_ret_idx <= o_ret_last ? '0 : r_ret_idx + IDX_W'(1);
         end
      end
   end

   assign o_pend     = r_pend;
   assign o_issue_ok = (w_pend_next < PEND_W'(MAX_PEND));
   assign o_ret_idx  = r_ret_idx;
   assign o_ret_last = i_rdv && (r_ret_idx == IDX_W'(N_IN - 1));

endmodule

// File: rtl/sdram_layer_engine.sv
// ---------------------------------------------------------------------------
// sdram_layer_engine
// Avalon-MM master evaluating one fully-connected layer stored in SDRAM:
// reads N_IN inputs, then N_OUT rows of N_IN weights (row-major, contiguous
// from WT_BASE), accumulates signed products per row, saturates to DATA_W and
// writes the N_OUT results from OUT_BASE.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start / done / busy  : HPS handshake (start is a level; a rising edge in
//                          IDLE launches a pass, done holds until start falls)
//   chipselect, read_n, write_n, address, byteenable, writedata : Avalon out
//   waitrequest, readdatavalid, readdata                        : Avalon in
// Build option: define RELU_EN to clamp every stored result at zero.
// ---------------------------------------------------------------------------
module sdram_layer_engine
   import sdram_layer_pkg::*;
#(
   parameter int N_IN     = 784,
   parameter int N_OUT    = 200,
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 40,
   parameter int ADDR_W   = 32,
   parameter int IN_BASE  = 0,
   parameter int WT_BASE  = 784,
   parameter int OUT_BASE = 158000,
   parameter int MAX_PEND = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     done,
   output logic                     busy,
   output logic                     chipselect,
   output logic                     read_n,
   output logic                     write_n,
   output logic [ADDR_W-1:0]        address,
   output logic [DATA_W/8-1:0]      byteenable,
   input  logic                     waitrequest,
   input  logic                     readdatavalid,
   input  logic signed [DATA_W-1:0] readdata,
   output logic signed [DATA_W-1:0] writedata
);

   localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int PEND_W = $clog2(MAX_PEND + 1);
   localparam int CNT_W  = $clog2(N_IN * N_OUT + 1);
   localparam int ROW_W  = $clog2(N_OUT + 1);
   localparam int BE_W   = DATA_W / 8;

   state_t                    r_state, w_state_next;
   logic                      r_start_d;
   logic                      r_done, r_busy, r_cs, r_read_n, r_write_n;
   logic [ADDR_W-1:0]         r_address;
   logic [BE_W-1:0]           r_be;
   logic signed [DATA_W-1:0]  r_writedata;
   logic [CNT_W-1:0]          r_iss_cnt, w_iss_next, w_iss_total;
   logic [ROW_W-1:0]          r_row, r_wr_cnt, w_wr_next;
   logic signed [ACC_W-1:0]   r_acc, w_acc_new;
   logic signed [DATA_W-1:0]  r_in_buf  [N_IN];
   logic signed [DATA_W-1:0]  r_res_buf [N_OUT];
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [DATA_W-1:0]  w_sat, w_res;
   logic [ADDR_W-1:0]         w_rd_base;
   logic                      w_active, w_rd_acc, w_wr_acc, w_rdv;
   logic                      w_issue_ok, w_ret_last;
   logic [PEND_W-1:0]         w_pend;
   logic [IDX_W-1:0]          w_ret_idx;

   // Returns outside a pass (e.g. stragglers after a reset) are dropped here.
   assign w_active    = (r_state == ST_LOAD_IN) || (r_state == ST_FETCH_W);
   assign w_rd_acc    = w_active && !r_read_n && !waitrequest;
   assign w_wr_acc    = (r_state == ST_WRITE) && !r_write_n && !waitrequest;
   assign w_rdv       = w_active && readdatavalid;
   assign w_iss_total = (r_state == ST_LOAD_IN) ? CNT_W'(N_IN) : CNT_W'(N_IN * N_OUT);
   assign w_iss_next  = r_iss_cnt + {{(CNT_W-1){1'b0}}, w_rd_acc};
   assign w_rd_base   = (r_state == ST_LOAD_IN) ? ADDR_W'(IN_BASE) : ADDR_W'(WT_BASE);
   assign w_wr_next   = r_wr_cnt + ROW_W'(1);

   // Product uses the return index, so it pairs with the word actually arriving.
   assign w_prod    = r_in_buf[w_ret_idx] * readdata;
   assign w_acc_new = ((w_ret_idx == '0) ? {ACC_W{1'b0}} : r_acc)
                    + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
   assign w_sat     = DATA_W'(sat_to_data_w(64'(w_acc_new), DATA_W));

   // Optional rectification of the saturated result.
   always_comb begin
      w_res = w_sat;
`ifdef RELU_EN
      if (w_sat[DATA_W-1]) begin
         w_res = '0;
      end else begin
         w_res = w_sat;
      end
`endif
   end

   sdram_rd_tracker #(
      .N_IN     (N_IN),
      .MAX_PEND (MAX_PEND),
      .PEND_W   (PEND_W),
      .IDX_W    (IDX_W)
   ) u_rd_tracker (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (r_state == ST_IDLE),
      .i_rd_acc   (w_rd_acc),
      .i_rdv      (w_rdv),
      .o_pend     (w_pend),
      .o_issue_ok (w_issue_ok),
      .o_ret_idx  (w_ret_idx),
      .o_ret_last (w_ret_last)
   );

   // FSM state register and start edge history (reset to 1 so a start held
   // through reset does not relaunch a pass).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_start_d <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_start_d <= start;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start && !r_start_d) w_state_next = ST_LOAD_IN;
            else                     w_state_next = ST_IDLE;
         end
         ST_LOAD_IN: begin
            if (w_ret_last) w_state_next = ST_FETCH_W;
            else            w_state_next = ST_LOAD_IN;
         end
         ST_FETCH_W: begin
            if ((r_row == ROW_W'(N_OUT)) && (w_pend == '0)) w_state_next = ST_WRITE;
            else                                            w_state_next = ST_FETCH_W;
         end
         ST_WRITE: begin
            if (w_wr_acc && (r_wr_cnt == ROW_W'(N_OUT - 1))) w_state_next = ST_DONE;
            else                                             w_state_next = ST_WRITE;
         end
         ST_DONE: begin
            if (!start) w_state_next = ST_IDLE;
            else        w_state_next = ST_DONE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Avalon request generation, counters, accumulator and handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cs        <= 1'b1;
         r_be        <= BE_W'(BE_ALL_ONES);
         r_read_n    <= 1'b1;
         r_write_n   <= 1'b1;
         r_address   <= '0;
         r_writedata <= '0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_iss_cnt   <= '0;
         r_row       <= '0;
         r_wr_cnt    <= '0;
         r_acc       <= '0;
      end else begin
         r_cs   <= 1'b1;
         r_be   <= BE_W'(BE_ALL_ONES);
         r_done <= (w_state_next == ST_DONE);
         r_busy <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
         case (r_state)
            ST_LOAD_IN, ST_FETCH_W: begin
               if (w_rdv && (r_state == ST_FETCH_W)) begin
                  r_acc <= w_acc_new;
                  if (w_ret_last) r_row <= r_row + ROW_W'(1);
               end
               if (w_state_next != r_state) begin
                  r_iss_cnt <= '0;
                  r_read_n  <= 1'b1;
                  if (w_state_next == ST_WRITE) begin
                     r_write_n   <= 1'b0;
                     r_address   <= ADDR_W'(OUT_BASE);
                     r_writedata <= r_res_buf[0];
                     r_wr_cnt    <= '0;
                  end
               end else if (!r_read_n && waitrequest) begin
                  // Stalled: request stays exactly as presented.
                  r_read_n <= 1'b0;
               end else begin
                  r_iss_cnt <= w_iss_next;
                  if ((w_iss_next < w_iss_total) && w_issue_ok) begin
                     r_read_n  <= 1'b0;
                     r_address <= w_rd_base + ADDR_W'(w_iss_next);
                  end else begin
                     r_read_n <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (w_wr_acc) begin
                  r_wr_cnt <= w_wr_next;
                  if (w_wr_next < ROW_W'(N_OUT)) begin
                     r_address   <= ADDR_W'(OUT_BASE) + ADDR_W'(w_wr_next);
                     r_writedata <= r_res_buf[w_wr_next];
                  end else begin
                     r_write_n <= 1'b1;
                  end
               end
            end
            default: begin
               // IDLE / DONE: bus quiet, per-pass state cleared.
               r_read_n  <= 1'b1;
               r_write_n <= 1'b1;
               r_iss_cnt <= '0;
               r_row     <= '0;
               r_wr_cnt  <= '0;
               r_acc     <= '0;
            end
         endcase
      end
   end

   // Input and result buffers (RAM-style, no reset).
   always_ff @(posedge clk) begin
      if (w_rdv && (r_state == ST_LOAD_IN)) r_in_buf[w_ret_idx] <= readdata;
      if (w_ret_last && (r_state == ST_FETCH_W)) r_res_buf[r_row] <= w_res;
   end

   assign done       = r_done;
   assign busy       = r_busy;
   assign chipselect = r_cs;
   assign read_n     = r_read_n;
   assign write_n    = r_write_n;
   assign address    = r_address;
   assign byteenable = r_be;
   assign writedata  = r_writedata;

endmodule

// File: tb/tb_sdram_layer_engine.sv
// ---------------------------------------------------------------------------
// tb_sdram_layer_engine
// Bench for sdram_layer_engine with N_IN=4, N_OUT=2, MAX_PEND=2. A negedge
// slave model serves reads from a word array with latency 3 and optional
// random waitrequest; expected results are computed directly from the array
// contents as dot products with clamping.
// ---------------------------------------------------------------------------
module tb_sdram_layer_engine;

   localparam int NI = 4, NO = 2, LAT = 3, OB = 100, WB = 4;

   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic done, busy, chipselect, read_n, write_n;
   logic [31:0] address;
   logic [1:0]  byteenable;
   logic waitrequest = 1'b0, readdatavalid = 1'b0;
   logic [15:0] readdata = 16'h0000, writedata;

   typedef struct { int due; logic [15:0] data; } rd_t;
   typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
   rd_t pipe[$];
   wr_t wlog[$];
   logic signed [15:0] mem [256];
   logic [15:0] exp_r [NO];
   int checks = 0, failures = 0;
   int cyc = 0, reads_acc = 0, writes_acc = 0, outstanding = 0, max_pend = 0;
   int stall_viol = 0, late_rdv = 0;
   bit rand_wait = 1'b0, prev_stall = 1'b0;
   logic [31:0] prev_addr;
   logic prev_rn, prev_wn;
   logic [15:0] prev_wd;

   sdram_layer_engine #(
      .N_IN(NI), .N_OUT(NO), .DATA_W(16), .ACC_W(40), .ADDR_W(32),
      .IN_BASE(0), .WT_BASE(WB), .OUT_BASE(OB), .MAX_PEND(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
      .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
      .address(address), .byteenable(byteenable), .waitrequest(waitrequest),
      .readdatavalid(readdatavalid), .readdata(readdata), .writedata(writedata)
   );

   always #5 clk = ~clk;

   // Slave model: drives the Avalon inputs at negedge, records accepted transfers.
   always @(negedge clk) begin
      rd_t e;
      wr_t w;
      bit acc;
      cyc = cyc + 1;
      if (prev_stall && (address !== prev_addr || read_n !== prev_rn || write_n !== prev_wn ||
                         (!write_n && writedata !== prev_wd)))
         stall_viol++;
      waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
         readdatavalid = 1'b1;
         readdata = pipe[0].data;
         void'(pipe.pop_front());
         if (outstanding > 0) outstanding--;
         if (!busy) late_rdv++;
      end else begin
         readdatavalid = 1'b0;
         readdata = 16'($urandom);
      end
      acc = !reset && !waitrequest && (!read_n || !write_n);
      if (acc && !read_n) begin
         e.due = cyc + LAT;
         e.data = mem[address[7:0]];
         pipe.push_back(e);
         reads_acc++;
         outstanding++;
      end
      if (acc && !write_n) begin
         w.addr = address;
         w.data = writedata;
         wlog.push_back(w);
         mem[address[7:0]] = writedata;
         writes_acc++;
      end
      if (reset) outstanding = 0;
      if (outstanding > max_pend) max_pend = outstanding;
      prev_stall = !reset && waitrequest && (!read_n || !write_n);
      prev_addr = address; prev_rn = read_n; prev_wn = write_n; prev_wd = writedata;
   end

   task automatic set_data(input int in_v[NI], input int w_v[NI*NO]);
      for (int k = 0; k < NI; k++) mem[k] = 16'(in_v[k]);
      for (int k = 0; k < NI*NO; k++) mem[WB+k] = 16'(w_v[k]);
   endtask

   // Reference: per-row dot product, clamped to 16-bit signed (and at 0 with RELU_EN).
   task automatic compute_expected();
      for (int n = 0; n < NO; n++) begin
         longint acc = 0;
         for (int k = 0; k < NI; k++)
            acc += longint'(mem[k]) * longint'(mem[WB + n*NI + k]);
         if (acc > 32767) acc = 32767;
         if (acc < -32768) acc = -32768;
`ifdef RELU_EN
         if (acc < 0) acc = 0;
`endif
         exp_r[n] = 16'(acc);
      end
   endtask

   task automatic run_pass(output bit timed_out);
      wlog.delete();
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      timed_out = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin timed_out = 1'b0; break; end
      end
   endtask

   task automatic end_pass();
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (read_n !== 1'b1) begin failures++; $display("FAIL rst_read_n got=%b exp=1", read_n); end
      checks++; if (write_n !== 1'b1) begin failures++; $display("FAIL rst_write_n got=%b exp=1", write_n); end
      checks++; if (chipselect !== 1'b1) begin failures++; $display("FAIL rst_cs got=%b exp=1", chipselect); end
      checks++; if (byteenable !== 2'b11) begin failures++; $display("FAIL rst_be got=%b exp=11", byteenable); end
      checks++; if (address !== 32'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", address); end
      checks++; if (writedata !== 16'd0) begin failures++; $display("FAIL rst_wdata got=%0d exp=0", writedata); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
   endtask

   task automatic test_basic(input string nm, input bit rw);
      bit to;
      int r0;
      set_data('{1, 2, 3, 4}, '{1, 1, 1, 1, -1, 0, 0, 0});
      compute_expected();
      rand_wait = rw; stall_viol = 0; max_pend = 0;
      r0 = reads_acc;
      run_pass(to);
      checks++; if (to) begin failures++; $display("FAIL %s_timeout done never rose", nm); end
      checks++; if (reads_acc - r0 !== NI*(NO+1)) begin failures++; $display("FAIL %s_nreads got=%0d exp=%0d", nm, reads_acc - r0, NI*(NO+1)); end
      checks++; if (wlog.size() !== NO) begin failures++; $display("FAIL %s_nwrites got=%0d exp=%0d", nm, wlog.size(), NO); end
      for (int j = 0; j < wlog.size() && j < NO; j++) begin
         checks++;
         if (wlog[j].addr !== 32'(OB + j) || wlog[j].data !== exp_r[j]) begin
            failures++;
            $display("FAIL %s_write%0d got=%0d<=%0d exp=%0d<=%0d", nm, j, wlog[j].addr, $signed(wlog[j].data), OB + j, $signed(exp_r[j]));
         end
      end
      if (rw) begin
         checks++; if (stall_viol !== 0) begin failures++; $display("FAIL %s_stall_stable got=%0d changes exp=0", nm, stall_viol); end
         checks++; if (max_pend > 2) begin failures++; $display("FAIL %s_max_pend got=%0d exp<=2", nm, max_pend); end
      end
      rand_wait = 1'b0;
      end_pass();
   endtask

   task automatic test_random_data();
      bit to;
      int in_v[NI], w_v[NI*NO];
      for (int it = 0; it < 4; it++) begin
         for (int k = 0; k < NI; k++)
            in_v[k] = (it < 2) ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 65535)) - 32768;
         for (int k = 0; k < NI*NO; k++)
            w_v[k] = (it < 2) ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 65535)) - 32768;
         set_data(in_v, w_v);
         compute_expected();
         rand_wait = it[0];
         run_pass(to);
         checks++; if (to) begin failures++; $display("FAIL rand%0d_timeout done never rose", it); end
         checks++; if (wlog.size() !== NO) begin failures++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", it, wlog.size(), NO); end
         for (int j = 0; j < wlog.size() && j < NO; j++) begin
            checks++;
            if (wlog[j].addr !== 32'(OB + j) || wlog[j].data !== exp_r[j]) begin
               failures++;
               $display("FAIL rand%0d_write%0d got=%0d<=%0d exp=%0d<=%0d", it, j, wlog[j].addr, $signed(wlog[j].data), OB + j, $signed(exp_r[j]));
            end
         end
         rand_wait = 1'b0;
         end_pass();
      end
   endtask

   task automatic test_saturation();
      bit to;
      logic [15:0] lim;
      for (int s = 0; s < 2; s++) begin
         int wv = (s == 0) ? 32767 : -32767;
         set_data('{32767, 32767, 32767, 32767}, '{wv, wv, wv, wv, wv, wv, wv, wv});
`ifdef RELU_EN
         lim = (s == 0) ? 16'h7FFF : 16'h0000;
`else
         lim = (s == 0) ? 16'h7FFF : 16'h8000;
`endif
         run_pass(to);
         checks++; if (to) begin failures++; $display("FAIL sat%0d_timeout done never rose", s); end
         checks++; if (wlog.size() !== NO) begin failures++; $display("FAIL sat%0d_nwrites got=%0d exp=%0d", s, wlog.size(), NO); end
         for (int j = 0; j < wlog.size() && j < NO; j++) begin
            checks++;
            if (wlog[j].data !== lim) begin
               failures++;
               $display("FAIL sat%0d_write%0d got=%0d exp=%0d", s, j, $signed(wlog[j].data), $signed(lim));
            end
         end
         end_pass();
      end
   endtask

   task automatic test_reset_mid();
      bit to, seen;
      int r0, w0;
      set_data('{5, -6, 7, 8}, '{2, 3, -4, 5, 1, -1, 1, -1});
      compute_expected();
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      r0 = reads_acc; seen = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         if (reads_acc - r0 >= NI + 2) begin seen = 1'b1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL rmid_reach_fetch reads=%0d exp>=%0d", reads_acc - r0, NI + 2); end
      late_rdv = 0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (read_n !== 1'b1) begin failures++; $display("FAIL rmid_read_n got=%b exp=1", read_n); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", done); end
      r0 = reads_acc; w0 = writes_acc;
      repeat (12) @(negedge clk);
      checks++; if (late_rdv < 1) begin failures++; $display("FAIL rmid_late_rdv got=%0d exp>=1", late_rdv); end
      checks++; if (reads_acc !== r0 || writes_acc !== w0) begin failures++; $display("FAIL rmid_no_restart reads=%0d writes=%0d exp=0/0", reads_acc - r0, writes_acc - w0); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_idle busy=%b done=%b exp=0/0", busy, done); end
      run_pass(to);
      checks++; if (to) begin failures++; $display("FAIL rmid_timeout done never rose"); end
      checks++; if (wlog.size() !== NO) begin failures++; $display("FAIL rmid_nwrites got=%0d exp=%0d", wlog.size(), NO); end
      for (int j = 0; j < wlog.size() && j < NO; j++) begin
         checks++;
         if (wlog[j].addr !== 32'(OB + j) || wlog[j].data !== exp_r[j]) begin
            failures++;
            $display("FAIL rmid_write%0d got=%0d<=%0d exp=%0d<=%0d", j, wlog[j].addr, $signed(wlog[j].data), OB + j, $signed(exp_r[j]));
         end
      end
      end_pass();
   endtask

   task automatic test_handshake();
      bit to, fell;
      int r0;
      wr_t first[$];
      set_data('{3, -1, 4, 1}, '{-5, 9, 2, 6, 5, 3, -5, 8});
      compute_expected();
      run_pass(to);
      checks++; if (to) begin failures++; $display("FAIL hs_timeout1 done never rose"); end
      first = wlog;
      r0 = reads_acc;
      repeat (40) @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL hs_done_held got=%b exp=1", done); end
      checks++; if (reads_acc !== r0 || wlog.size() !== first.size()) begin failures++; $display("FAIL hs_no_second_pass reads=%0d exp=0", reads_acc - r0); end
      #1 start = 1'b0;
      fell = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done === 1'b0) begin fell = 1'b1; break; end
      end
      checks++; if (!fell) begin failures++; $display("FAIL hs_done_fall got=%b exp=0", done); end
      run_pass(to);
      checks++; if (to) begin failures++; $display("FAIL hs_timeout2 done never rose"); end
      checks++; if (wlog.size() !== NO) begin failures++; $display("FAIL hs_nwrites got=%0d exp=%0d", wlog.size(), NO); end
      for (int j = 0; j < wlog.size() && j < NO; j++) begin
         checks++;
         if (wlog[j].addr !== 32'(OB + j) || wlog[j].data !== exp_r[j]) begin
            failures++;
            $display("FAIL hs_write%0d got=%0d<=%0d exp=%0d<=%0d", j, wlog[j].addr, $signed(wlog[j].data), OB + j, $signed(exp_r[j]));
         end
      end
      end_pass();
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
      test_reset();
      test_basic("zero_wait", 1'b0);
      test_basic("rand_wait", 1'b1);
      test_random_data();
      test_saturation();
      test_reset_mid();
      test_handshake();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
